mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux among 8 requesters.
- Sequences the mux select so each requester owns the datapath for a burst.
- Sits in front of the mux: drives its 3-bit sel and a valid/grant handshake back to the requesters.
- Registered outputs; the mux itself stays combinational and external.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner when the timeout feature is compiled in (legal range 2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the mux.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  mux select, binary index of the current owner; drives the mux sel[2:0].
- valid  output  1  high when gnt is non-zero (mux output is meaningful).
- owner_chg  output  1  one-cycle pulse on the first cycle of every new grant.

Behaviour:
- Reset values (async assert, sync deassert by the user): gnt=0, sel=0, valid=0, owner_chg=0, state=IDLE, rr pointer ptr=0, hold counter=0.
- ptr is the highest-priority index for the next arbitration. The search order is ptr, ptr+1, ... ptr+7, mod 8 (3-bit wrap, 7->0).
- IDLE:
  - req==0: stay; outputs 0.
  - req!=0: pick the first set bit in search order. Next edge: gnt=onehot(w), sel=w, valid=1, owner_chg=1, ptr=w+1 mod 8, counter=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT (owner o):
  - req[o]==1, no forced release: hold gnt, sel and valid; owner_chg=0; counter increments, saturating at MAX_HOLD-1.
  - req[o]==0 (release), other requests pending: re-arbitrate in the same cycle over req with ptr. The new owner is granted at the next edge with no idle bubble, and owner_chg=1.
  - req[o]==0, req==0: next edge gnt=0, sel keeps its last value, valid=0, state=IDLE.
  - A requester that drops and re-raises req in consecutive cycles is treated as a new request and competes normally.
- sel changes only on owner changes. It is never X and never glitches through intermediate values, because it is registered.
- gnt is always one-hot or zero. Any other value is a bug and triggers an assertion in the bench.
- Simultaneous requests are resolved purely by ptr. There is no fixed priority.
- Reset mid-burst: all outputs drop to 0 asynchronously and ptr returns to 0. There is no recovery of the previous owner.

Optional Feature:
- Macro: MUX8_ARB_TIMEOUT_EN.
- Defined:
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, the owner is forcibly released.
  - Next edge grants the next requester in search order, excluding o, with owner_chg=1.
  - If no other requester is waiting, the owner keeps the grant and the counter restarts at 0.
- Undefined: the counter logic is absent; the owner holds until it drops req. MAX_HOLD and CNT_W are ignored.

Decomposition:
- Shared package/header holds:
  - constants N_REQ=8 and SEL_W=3;
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - the default MAX_HOLD.
- One natural sub-module: rr_pick8.
  - Combinational rotate-priority encoder with inputs req[7:0], ptr[2:0], mask[7:0].
  - Outputs: found, idx[2:0].
  - The top instantiates it once. mask excludes the current owner during a forced release.

Test Plan:
- Reset/idle: assert rst mid-grant with req=8'hFF -> gnt=0, sel=0, valid=0 immediately. Deassert with req=0 -> outputs stay 0.
- Single requester: req=8'h10 at cycle 0 -> cycle 1 gnt=8'h10, sel=4, valid=1, owner_chg=1. Hold for 5 cycles, then drop -> gnt=0 one cycle later.
- Round robin: req=8'hFF, each owner drops req for one cycle after 2 cycles of ownership -> sel sequence 0,1,2,...,7,0 with no idle cycles between owners.
- Wrap and pointer: ptr=6 after granting 5; req=8'h21 -> sel=0 is granted, not 5. Next grant with req=8'h21 goes to 5.
- Timeout (MUX8_ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held constantly -> sel alternates 0,0,0,0,1,1,1,1,0...; with req=8'h01 only, gnt stays 8'h01 indefinitely.
- Without macro, same req=8'h03 stimulus -> sel stays 0 until req[0] drops.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot decode of a requester index into a grant vector.
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating-priority encoder: finds the first set bit of (req & mask) searching
// ptr, ptr+1, ... ptr+7 with 3-bit wrap. Purely combinational.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pos;

  // Walk the eight positions starting at ptr; the first candidate wins.
  always_comb begin
    cand  = req & mask;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = ptr + SEL_W'(k);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an external 8:1 mux.
// Registered gnt/sel/valid/owner_chg; one-cycle request-to-grant latency and
// no idle bubble when ownership passes directly between requesters.
// Optional build macro MUX8_ARB_TIMEOUT_EN: adds a hold counter that forces
// the owner off after MAX_HOLD consecutive cycles when someone else waits.
//
// Handshake: valid is high exactly when gnt is non-zero; while valid is high,
// sel is the binary index of the single set gnt bit and the mux output belongs
// to that requester. A requester keeps ownership by holding its req bit high;
// dropping it for one cycle releases the mux, and raising it again later is a
// fresh request.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             owner_chg
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             owner_chg_q, owner_chg_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             own_req;
  logic             force_rel;
  logic             take_new;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit;

  // Forced release only when the owner still wants the mux, has used its
  // full slot, and somebody else is actually waiting.
  always_comb begin
    at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    force_rel = (state_q == ST_GRANT) && own_req && at_limit &&
                (|(req & ~gnt_q));
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_HOLD), 32'(CNT_W)};
  assign force_rel  = 1'b0;
`endif

  assign own_req = req[sel_q];

  // The current owner is masked out only during a forced release so the
  // search lands on the next waiting requester; otherwise all bits compete.
  assign pick_mask = force_rel ? ~gnt_q : {N_REQ{1'b1}};

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register plus all registered outputs; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      owner_chg_q <= 1'b0;
      ptr_q       <= '0;
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      owner_chg_q <= owner_chg_d;
      ptr_q       <= ptr_d;
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state: decide whether a new owner is granted this edge or the
  // arbiter falls back to idle.
  always_comb begin
    state_d  = state_q;
    take_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          take_new = 1'b1;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!own_req || force_rel) begin
          if (pick_found) begin
            take_new = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values. sel only moves on a new grant, so the mux
  // select never passes through intermediate indices.
  always_comb begin
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    owner_chg_d = 1'b0;
    ptr_d       = ptr_q;
`ifdef MUX8_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    if (take_new) begin
      gnt_d       = onehot8(pick_idx);
      sel_d       = pick_idx;
      valid_d     = 1'b1;
      owner_chg_d = 1'b1;
      ptr_d       = pick_idx + SEL_W'(1);
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_d       = '0;
`endif
    end else if (state_q == ST_GRANT && state_d == ST_IDLE) begin
      gnt_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == ST_GRANT) begin
`ifdef MUX8_ARB_TIMEOUT_EN
      // Owner keeps the mux: count its slot; at the limit with nobody
      // waiting the slot simply restarts.
      cnt_d = at_limit ? '0 : cnt_q + CNT_W'(1);
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign valid     = valid_q;
  assign owner_chg = owner_chg_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       owner_chg;

  int checks;
  int errors;

  // Observed outputs packed as {gnt, sel, valid, owner_chg}.
  logic [12:0] obs;
  assign obs = {gnt, sel, valid, owner_chg};

  mux8_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .valid     (valid),
    .owner_chg (owner_chg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grant invariants sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(gnt) || (valid !== (gnt != 8'h00)) ||
          (valid && gnt !== (8'h01 << sel))) begin
        errors++;
        $display("FAIL invariant: gnt=%h sel=%0d valid=%b", gnt, sel, valid);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    checks++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 13'h0) begin
        errors++;
        $display("FAIL idle_no_req[%0d]: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_single();
    req = 8'h10;
    tick();
    checks++;
    if (obs !== {8'h10, 3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: got %h want %h", obs, {8'h10, 3'd4, 1'b1, 1'b1});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_hold[%0d]: got %h want %h", i, obs, {8'h10, 3'd4, 1'b1, 1'b0});
      end
    end
    req = 8'h00;
    tick();
    checks++;
    if (obs !== {8'h00, 3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_release: got %h want %h", obs, {8'h00, 3'd4, 1'b0, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 8; k++) begin
      e_gnt = 8'h01 << k;
      e_sel = 3'(k);
      checks++;
      if (obs !== {e_gnt, e_sel, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h want %h", k, obs, {e_gnt, e_sel, 1'b1, 1'b1});
      end
      tick();
      checks++;
      if (obs !== {e_gnt, e_sel, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rr_hold[%0d]: got %h want %h", k, obs, {e_gnt, e_sel, 1'b1, 1'b0});
      end
      req[k] = 1'b0;
      tick();
      req[k] = 1'b1;
    end
    checks++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rr_wrap_to_0: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b1});
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_wrap_ptr();
    do_reset();
    req = 8'h20;
    tick();
    checks++;
    if (obs !== {8'h20, 3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_first5: got %h want %h", obs, {8'h20, 3'd5, 1'b1, 1'b1});
    end
    req = 8'h00;
    tick();
    req = 8'h21;
    tick();
    checks++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_ptr6_picks0: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b1});
    end
    req = 8'h00;
    tick();
    req = 8'h21;
    tick();
    checks++;
    if (obs !== {8'h20, 3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_ptr1_picks5: got %h want %h", obs, {8'h20, 3'd5, 1'b1, 1'b1});
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    req = 8'hFF;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL async_reset_mid_grant: got %h want 0", obs);
    end
    req = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL after_reset_idle: got %h want 0", obs);
    end
  endtask

`ifdef MUX8_ARB_TIMEOUT_EN
  task automatic test_hold();
    logic [2:0] e_sel;
    logic       e_oc;
    do_reset();
    req = 8'h03;
    for (int i = 0; i < 16; i++) begin
      tick();
      e_sel = 3'((i / 4) % 2);
      e_oc  = (i % 4 == 0);
      checks++;
      if (obs !== {8'h01 << e_sel, e_sel, 1'b1, e_oc}) begin
        errors++;
        $display("FAIL timeout_alt[%0d]: got %h want %h", i, obs, {8'h01 << e_sel, e_sel, 1'b1, e_oc});
      end
    end
    do_reset();
    req = 8'h01;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL timeout_sole_owner[%0d]: got %h want %h", i, obs, {8'h01, 3'd0, 1'b1, 1'b0});
      end
    end
    req = 8'h00;
    tick();
  endtask
`else
  task automatic test_hold();
    do_reset();
    req = 8'h03;
    tick();
    checks++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_first: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b1});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_no_timeout[%0d]: got %h want %h", i, obs, {8'h01, 3'd0, 1'b1, 1'b0});
      end
    end
    req = 8'h02;
    tick();
    checks++;
    if (obs !== {8'h02, 3'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_handover: got %h want %h", obs, {8'h02, 3'd1, 1'b1, 1'b1});
    end
    req = 8'h00;
    tick();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_ptr();
    test_reset_mid_grant();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
